// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: RV32 opcode classes (instr[6:2]),
// encoding format IDs and the opcode/funct3 to format mapping.
package instr_encoder_pkg;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_MISCMEM = 5'b00011;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_OP      = 5'b01100;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    localparam logic [31:0] ILLEGAL_WORD_DFLT = 32'h0000_0000;

    // FMT_ISH is the I-type shift-immediate form (funct7 + 5-bit shamt)
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [4:0] opcode, input logic [2:0] funct3);
        fmt_e f;
        case (opcode)
            OP_OP:     f = FMT_R;
            OP_OPIMM:  f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_ISH : FMT_I;
            OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISCMEM: f = FMT_I;
            OP_STORE:  f = FMT_S;
            OP_BRANCH: f = (funct3 == 3'b010 || funct3 == 3'b011) ? FMT_BAD : FMT_B;
            OP_LUI, OP_AUIPC: f = FMT_U;
            OP_JAL:    f = FMT_J;
            default:   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_fmt_pack.sv
// Combinational field packer: instruction fields in, {err, word} out.
// Out-of-range immediates and unknown opcodes produce err=1 and ILLEGAL_WORD.
module instr_fmt_pack
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_WORD = ILLEGAL_WORD_DFLT
) (
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        err,
    output logic [31:0] word
);

    fmt_e        fmt;
    logic        ok;
    logic        i_ok, b_ok, j_ok, u_ok;
    logic [31:0] raw;

    always_comb begin
        fmt  = fmt_of(opcode, funct3);
        // sign-extension checks: every bit above the field must equal the sign bit
        i_ok = (&imm[31:11]) | ~(|imm[31:11]);
        b_ok = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
        j_ok = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
        u_ok = ~(|imm[11:0]);
        raw  = '0;
        ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                raw = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
                ok  = 1'b1;
            end
            FMT_I: begin
                raw = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
                ok  = i_ok;
            end
            FMT_ISH: begin
                raw = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
                ok  = 1'b1;
            end
            FMT_S: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
                ok  = i_ok;
            end
            FMT_B: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
                ok  = b_ok;
            end
            FMT_U: begin
                raw = {imm[31:12], rd, opcode, 2'b11};
                ok  = u_ok;
            end
            FMT_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                ok  = j_ok;
            end
            default: begin
                raw = '0;
                ok  = 1'b0;
            end
        endcase
        err  = ~ok;
        word = ok ? raw : ILLEGAL_WORD;
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field-level requests into RV32IM words and queues
// them, with their error flag, in a DEPTH-entry FIFO with valid/ready on both sides.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] ILLEGAL_WORD = ILLEGAL_WORD_DFLT
) (
    input  logic                     I_clk,
    input  logic                     I_reset,
    input  logic                     I_valid,
    output logic                     O_ready,
    input  logic [4:0]               I_opcode,
    input  logic [4:0]               I_rd,
    input  logic [4:0]               I_rs1,
    input  logic [4:0]               I_rs2,
    input  logic [2:0]               I_funct3,
    input  logic [6:0]               I_funct7,
    input  logic [31:0]              I_imm,
    output logic                     O_valid,
    input  logic                     I_ready,
    output logic [31:0]              O_instr,
    output logic                     O_err,
    output logic [$clog2(DEPTH):0]   O_count
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [32:0]   mem [DEPTH];
    logic          enc_err;
    logic [31:0]   enc_word;
    logic          push, pop;

    instr_fmt_pack #(.ILLEGAL_WORD(ILLEGAL_WORD)) u_pack (
        .opcode (I_opcode),
        .rd     (I_rd),
        .rs1    (I_rs1),
        .rs2    (I_rs2),
        .funct3 (I_funct3),
        .funct7 (I_funct7),
        .imm    (I_imm),
        .err    (enc_err),
        .word   (enc_word)
    );

    // ready depends only on occupancy, so a full FIFO refuses even while popping
    assign O_ready = (count != FULL);
    assign O_valid = (count != '0);
    assign push    = I_valid && O_ready;
    assign pop     = O_valid && I_ready;
    assign O_instr = O_valid ? mem[rd_ptr][31:0] : ILLEGAL_WORD;
    assign O_err   = O_valid & mem[rd_ptr][32];
    assign O_count = count;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (push && !I_reset) mem[wr_ptr] <= {enc_err, enc_word};
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus randomized requests,
// expected words computed from the RV32 format rules with plain arithmetic.
module tb_instr_encoder;

    localparam int DEPTH = 2;

    localparam logic [4:0] T_LOAD = 5'd0,  T_MISC = 5'd3,  T_OPIMM = 5'd4,  T_AUIPC = 5'd5;
    localparam logic [4:0] T_STORE = 5'd8, T_OP = 5'd12,   T_LUI = 5'd13,   T_BRANCH = 5'd24;
    localparam logic [4:0] T_JALR = 5'd25, T_JAL = 5'd27,  T_SYSTEM = 5'd28;

    logic        I_clk = 1'b0;
    logic        I_reset, I_valid, I_ready;
    logic [4:0]  I_opcode, I_rd, I_rs1, I_rs2;
    logic [2:0]  I_funct3;
    logic [6:0]  I_funct7;
    logic [31:0] I_imm;
    logic        O_ready, O_valid, O_err;
    logic [31:0] O_instr;
    logic [$clog2(DEPTH):0] O_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit rand_mode = 1'b0;
    logic [32:0] q[$];

    always #5 I_clk = ~I_clk;

    instr_encoder #(.DEPTH(DEPTH), .ILLEGAL_WORD(32'h0)) dut (
        .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
        .I_opcode(I_opcode), .I_rd(I_rd), .I_rs1(I_rs1), .I_rs2(I_rs2),
        .I_funct3(I_funct3), .I_funct7(I_funct7), .I_imm(I_imm),
        .O_valid(O_valid), .I_ready(I_ready), .O_instr(O_instr), .O_err(O_err),
        .O_count(O_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {err, word} from the format rules, using signed ranges and shifts
    function automatic logic [32:0] ref_enc(input logic [4:0] op, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] imm);
        int signed   s;
        logic [31:0] base, w;
        bit          legal;
        s     = $signed(imm);
        base  = (32'(op) << 2) | 32'd3;
        legal = 1'b1;
        w     = 32'h0;
        if (op == T_OP) begin
            w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        end else if (op == T_OPIMM && (f3 == 3'd1 || f3 == 3'd5)) begin
            w = (32'(f7) << 25) | ((imm % 32) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        end else if (op == T_OPIMM || op == T_LOAD || op == T_JALR || op == T_SYSTEM || op == T_MISC) begin
            legal = (s >= -2048) && (s <= 2047);
            w = ((imm % 4096) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        end else if (op == T_STORE) begin
            legal = (s >= -2048) && (s <= 2047);
            w = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | ((imm % 32) << 7);
        end else if (op == T_BRANCH) begin
            legal = (s >= -4096) && (s <= 4095) && (s % 2 == 0) && f3 != 3'd2 && f3 != 3'd3;
            w = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
              | (32'(f3) << 12) | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7);
        end else if (op == T_LUI || op == T_AUIPC) begin
            legal = (imm % 4096) == 0;
            w = (imm - (imm % 4096)) | (32'(rd) << 7);
        end else if (op == T_JAL) begin
            legal = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            w = (((imm >> 20) % 2) << 31) | (((imm >> 1) % 1024) << 21) | (((imm >> 11) % 2) << 20)
              | (((imm >> 12) % 256) << 12) | (32'(rd) << 7);
        end else begin
            legal = 1'b0;
        end
        return legal ? {1'b0, w | base} : {1'b1, 32'h0};
    endfunction

    // Monitor/scoreboard: occupancy tracking, pops checked in order, accepted pushes queued
    always @(negedge I_clk) begin
        logic [32:0] e;
        if (mon_en) begin
            chk("count", 64'(O_count), 64'(q.size()));
            chk("o_valid", 64'(O_valid), 64'(q.size() != 0));
            chk("o_ready", 64'(O_ready), 64'(q.size() != DEPTH));
            if (I_reset) begin
                q.delete();
            end else begin
                if (O_valid && I_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL pop_empty: DUT presented %h, model queue empty", O_instr);
                    end else begin
                        e = q.pop_front();
                        chk("word", 64'(O_instr), 64'(e[31:0]));
                        chk("err", 64'(O_err), 64'(e[32]));
                    end
                end
                if (I_valid && O_ready)
                    q.push_back(ref_enc(I_opcode, I_rd, I_rs1, I_rs2, I_funct3, I_funct7, I_imm));
            end
        end
    end

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        I_opcode = op; I_rd = rd; I_rs1 = rs1; I_rs2 = rs2;
        I_funct3 = f3; I_funct7 = f7; I_imm = imm;
        I_valid  = 1'b1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        bit acc;
        set_req(op, rd, rs1, rs2, f3, f7, imm);
        for (int i = 0; i < 64; i++) begin
            acc = O_ready;
            tick();
            if (rand_mode) I_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                I_valid = 1'b0;
                return;
            end
        end
        I_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: request op %h not accepted in 64 cycles", op);
    endtask

    task automatic head(input string name, input logic [31:0] w, input logic e);
        chk({name, "_valid"}, 64'(O_valid), 64'(1));
        chk({name, "_instr"}, 64'(O_instr), 64'(w));
        chk({name, "_err"}, 64'(O_err), 64'(e));
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        int edges[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 1048574, -1048576, 1048576};
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       v = $urandom & 32'hFFFF_F000;
            3:       v = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
            default: v = 32'(edges[$urandom_range(0, 9)]);
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops[11] = '{T_LOAD, T_MISC, T_OPIMM, T_AUIPC, T_STORE, T_OP,
                                T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
        logic [4:0] op;
        I_reset = 1'b1; I_valid = 1'b0; I_ready = 1'b1;
        set_req(T_OP, 0, 0, 0, 0, 0, 0);
        I_valid = 1'b0;
        tick(); tick();
        I_reset = 1'b0;
        chk("rst_valid", 64'(O_valid), 64'(0));
        chk("rst_count", 64'(O_count), 64'(0));
        chk("rst_ready", 64'(O_ready), 64'(1));
        chk("rst_instr", 64'(O_instr), 64'(0));
        chk("rst_err", 64'(O_err), 64'(0));
        mon_en = 1'b1;

        send(T_OPIMM, 1, 0, 0, 3'd0, 7'd0, 32'd5);            head("addi", 32'h00500093, 1'b0);
        send(T_LUI, 2, 0, 0, 3'd0, 7'd0, 32'h12345000);       head("lui", 32'h12345137, 1'b0);
        send(T_LUI, 2, 0, 0, 3'd0, 7'd0, 32'h12345001);       head("lui_bad", 32'h0, 1'b1);
        send(T_BRANCH, 0, 1, 2, 3'd0, 7'd0, -32'sd4);         head("beq", 32'hFE208EE3, 1'b0);
        send(T_STORE, 0, 2, 5, 3'd2, 7'd0, 32'd8);            head("sw", 32'h00512423, 1'b0);
        send(T_JAL, 1, 0, 0, 3'd0, 7'd0, 32'd3);              head("jal_odd", 32'h0, 1'b1);
        send(T_JAL, 1, 0, 0, 3'd0, 7'd0, 32'h00100000);       head("jal_range", 32'h0, 1'b1);
        send(T_BRANCH, 0, 1, 2, 3'd2, 7'd0, 32'd8);           head("br_f3", 32'h0, 1'b1);
        send(5'b11111, 1, 2, 3, 3'd0, 7'd0, 32'd0);           head("bad_op", 32'h0, 1'b1);
        send(T_OPIMM, 3, 4, 0, 3'd5, 7'h20, 32'hFFFF_FFE7);   head("srai", 32'h40725193, 1'b0);
        tick();

        // backpressure: two accepts fill the FIFO, the third waits for the first pop
        I_ready = 1'b0;
        set_req(T_OPIMM, 1, 0, 0, 3'd0, 7'd0, 32'd5);         tick();
        set_req(T_LUI, 2, 0, 0, 3'd0, 7'd0, 32'h12345000);    tick();
        chk("bp_ready", 64'(O_ready), 64'(0));
        chk("bp_count", 64'(O_count), 64'(2));
        set_req(T_STORE, 0, 2, 5, 3'd2, 7'd0, 32'd8);         tick(); tick();
        chk("bp_hold_count", 64'(O_count), 64'(2));
        head("bp_hold", 32'h00500093, 1'b0);
        I_ready = 1'b1;                                        tick();
        chk("bp_pop1_count", 64'(O_count), 64'(1));
        head("bp_pop1", 32'h12345137, 1'b0);
        tick();
        I_valid = 1'b0;
        chk("bp_pop2_count", 64'(O_count), 64'(1));
        head("bp_third", 32'h00512423, 1'b0);
        tick();

        // reset with two entries pending
        I_ready = 1'b0;
        set_req(T_OPIMM, 1, 0, 0, 3'd0, 7'd0, 32'd5);         tick();
        set_req(T_LUI, 2, 0, 0, 3'd0, 7'd0, 32'h12345000);    tick();
        I_valid = 1'b0; I_reset = 1'b1;                        tick();
        I_reset = 1'b0;
        chk("mrst_valid", 64'(O_valid), 64'(0));
        chk("mrst_count", 64'(O_count), 64'(0));
        chk("mrst_ready", 64'(O_ready), 64'(1));
        chk("mrst_instr", 64'(O_instr), 64'(0));
        chk("mrst_err", 64'(O_err), 64'(0));
        I_ready = 1'b1;
        send(T_BRANCH, 0, 1, 2, 3'd0, 7'd0, -32'sd4);         head("post_rst", 32'hFE208EE3, 1'b0);

        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 10)];
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_mode = 1'b0;
        I_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("drain_count", 64'(O_count), 64'(0));
        chk("drain_queue", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
